// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-ported RAM between CPUS cache pairs (an icache and a
//   dcache per CPU). Data requests beat instruction requests. Within a type,
//   a 1-bit round-robin pointer picks the CPU.
//
//   Handshake: a requester holds its REN/WEN bit (and address/data) until it
//   sees its wait bit low. wait=0 lasts exactly one cycle (the completion
//   cycle), and load is valid only in that cycle. Dropping the request before
//   completion aborts the transaction silently.
//
// Ports
//   CLK, nRST                  clock, asynchronous active-low reset
//   iREN, iaddr                instruction read request/address per CPU
//   dREN, dWEN, daddr, dstore  data read/write request, address, data per CPU
//   iwait, iload               instruction stall / read data per CPU
//   dwait, dload               data stall / read data per CPU
//   ramREN, ramWEN             RAM enables
//   ramaddr, ramstore          RAM address / write data
//   ramload, ramstate          RAM read data / status (FREE,BUSY,ACCESS,ERROR)
//   ramerr                     sticky: some access completed with ERROR
//   dbg_state                  FSM state (0 = IDLE, 1 = SERVE)
module ram_arbiter #(
  parameter int          CPUS    = 2,
  parameter logic [31:0] ERRWORD = 32'hBAD0BAD0
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  iload,
  output logic [CPUS-1:0][31:0]  dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate,
  output logic                   ramerr,
  output logic                   dbg_state
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t state, next_state;
  logic   gnt_cpu, next_gnt_cpu;
  logic   gnt_d, next_gnt_d;
  logic   rr, next_rr;
  logic   next_ramerr;

  // Requests padded to two CPUs so the arbitration logic is the same for
  // CPUS=1; the phantom CPU1 never requests and so never wins.
  logic [1:0] ireq2, dreq2;
  assign ireq2 = 2'(iREN);
  assign dreq2 = 2'(dREN | dWEN);

  assign dbg_state = state;

  // The pointer's CPU wins if it requests, otherwise the other one does.
  function automatic logic pick(input logic [1:0] req, input logic ptr);
    if (req[ptr]) return ptr;
    return ~ptr;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      gnt_cpu <= 1'b0;
      gnt_d   <= 1'b0;
      rr      <= 1'b0;
      ramerr  <= 1'b0;
    end else begin
      state   <= next_state;
      gnt_cpu <= next_gnt_cpu;
      gnt_d   <= next_gnt_d;
      rr      <= next_rr;
      ramerr  <= next_ramerr;
    end
  end

  logic        live;
  logic [31:0] rdata;

  always_comb begin
    next_state   = state;
    next_gnt_cpu = gnt_cpu;
    next_gnt_d   = gnt_d;
    next_rr      = rr;
    next_ramerr  = ramerr;
    iwait        = '1;
    dwait        = '1;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    live         = 1'b0;
    rdata        = '0;

    case (state)
      IDLE: begin
        if (|dreq2) begin
          next_gnt_d   = 1'b1;
          next_gnt_cpu = pick(dreq2, rr);
          next_state   = SERVE;
        end else if (|ireq2) begin
          next_gnt_d   = 1'b0;
          next_gnt_cpu = pick(ireq2, rr);
          next_state   = SERVE;
        end
      end

      SERVE: begin
        live = gnt_d ? dreq2[gnt_cpu] : ireq2[gnt_cpu];
        if (!live) begin
          // Requester gave up: abort with RAM idle, pointer untouched.
          next_state = IDLE;
        end else begin
          if (gnt_d) begin
            ramWEN   = dWEN[gnt_cpu];
            ramREN   = dREN[gnt_cpu] & ~dWEN[gnt_cpu];
            ramaddr  = daddr[gnt_cpu];
            ramstore = dstore[gnt_cpu];
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr[gnt_cpu];
          end

          if (ramstate == RAM_ACCESS || ramstate == RAM_ERROR) begin
            rdata = (ramstate == RAM_ERROR) ? ERRWORD : ramload;
            if (gnt_d) begin
              dwait[gnt_cpu] = 1'b0;
              dload[gnt_cpu] = rdata;
            end else begin
              iwait[gnt_cpu] = 1'b0;
              iload[gnt_cpu] = rdata;
            end
            next_rr    = ~rr;
            next_state = IDLE;
            if (ramstate == RAM_ERROR) next_ramerr = 1'b1;
          end
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter (CPUS=2). Inputs change 1 time unit after
//   the rising edge; outputs are checked 1 unit later, well before the next edge.
module tb_ram_arbiter;

  logic              CLK;
  logic              nRST;
  logic [1:0]        iREN, dREN, dWEN;
  logic [1:0][31:0]  iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait;
  logic [1:0][31:0]  iload, dload;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
  logic              ramerr;
  logic              dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  ram_arbiter #(.CPUS(2), .ERRWORD(32'hBAD0BAD0)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;

    // reset state
    #3;
    chk("rst_iwait", 32'(iwait), 32'h3);
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ramWEN", 32'(ramWEN), 32'h0);
    chk("rst_ramerr", 32'(ramerr), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // single data read
    nxt; dREN = 2'b01; daddr[0] = 32'h100; ramstate = FREE; #1;
    chk("rd_idle_state", 32'(dbg_state), 32'h0);
    chk("rd_idle_dwait", 32'(dwait), 32'h3);
    chk("rd_idle_ramREN", 32'(ramREN), 32'h0);
    nxt; ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("rd_ramREN", 32'(ramREN), 32'h1);
    chk("rd_ramaddr", ramaddr, 32'h100);
    chk("rd_dwait", 32'(dwait), 32'h2);
    chk("rd_dload0", dload[0], 32'hDEADBEEF);
    chk("rd_dload1", dload[1], 32'h0);
    nxt; dREN = 2'b00; ramstate = FREE; #1;
    chk("rd_after_dwait", 32'(dwait), 32'h3);
    chk("rd_after_dload0", dload[0], 32'h0);
    chk("rd_after_ramaddr", ramaddr, 32'h0);

    // data write on CPU1 beats instruction read on CPU0
    nxt; iREN = 2'b01; iaddr[0] = 32'h200;
    dWEN = 2'b10; daddr[1] = 32'h300; dstore[1] = 32'h12345678; #1;
    chk("pri_idle_ramWEN", 32'(ramWEN), 32'h0);
    nxt; ramstate = BUSY; #1;
    chk("pri_busy_ramWEN", 32'(ramWEN), 32'h1);
    chk("pri_busy_ramREN", 32'(ramREN), 32'h0);
    chk("pri_busy_ramstore", ramstore, 32'h12345678);
    chk("pri_busy_ramaddr", ramaddr, 32'h300);
    chk("pri_busy_dwait", 32'(dwait), 32'h3);
    chk("pri_busy_iwait", 32'(iwait), 32'h3);
    nxt; ramstate = ACCESS; #1;
    chk("pri_d_dwait", 32'(dwait), 32'h1);
    chk("pri_d_iwait", 32'(iwait), 32'h3);
    nxt; dWEN = 2'b00; ramstate = FREE; #1;
    chk("pri_gap_state", 32'(dbg_state), 32'h0);
    chk("pri_gap_iwait", 32'(iwait), 32'h3);
    nxt; ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    chk("pri_i_ramREN", 32'(ramREN), 32'h1);
    chk("pri_i_ramWEN", 32'(ramWEN), 32'h0);
    chk("pri_i_ramaddr", ramaddr, 32'h200);
    chk("pri_i_iwait", 32'(iwait), 32'h2);
    chk("pri_i_iload0", iload[0], 32'hCAFEF00D);
    chk("pri_i_dwait", 32'(dwait), 32'h3);
    nxt; iREN = 2'b00; ramstate = FREE; #1;
    chk("pri_after_iload0", iload[0], 32'h0);
    chk("pri_after_iwait", 32'(iwait), 32'h3);

    // round robin from a fresh pointer (reset pulsed while idle)
    nRST = 1'b0; #1; nRST = 1'b1;
    nxt; dREN = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500;
    ramstate = ACCESS; ramload = 32'h11111111; #1;
    chk("rr_idle0_dwait", 32'(dwait), 32'h3);
    nxt; #1;
    chk("rr_g0_dwait", 32'(dwait), 32'h2);
    chk("rr_g0_ramaddr", ramaddr, 32'h400);
    chk("rr_g0_dload0", dload[0], 32'h11111111);
    nxt; #1;
    chk("rr_idle1_dwait", 32'(dwait), 32'h3);
    nxt; #1;
    chk("rr_g1_dwait", 32'(dwait), 32'h1);
    chk("rr_g1_ramaddr", ramaddr, 32'h500);
    chk("rr_g1_dload1", dload[1], 32'h11111111);
    nxt; #1;
    chk("rr_idle2_dwait", 32'(dwait), 32'h3);
    nxt; #1;
    chk("rr_g2_dwait", 32'(dwait), 32'h2);
    chk("rr_g2_ramaddr", ramaddr, 32'h400);

    // RAM error completion (pointer now at CPU1, only CPU0 asks)
    nxt; dREN = 2'b01; daddr[0] = 32'h600; ramstate = FREE; #1;
    chk("err_idle_state", 32'(dbg_state), 32'h0);
    nxt; ramstate = ERROR; ramload = 32'h55555555; #1;
    chk("err_dwait", 32'(dwait), 32'h2);
    chk("err_dload0", dload[0], 32'hBAD0BAD0);
    chk("err_ramerr_pre", 32'(ramerr), 32'h0);
    nxt; dREN = 2'b00; ramstate = FREE; #1;
    chk("err_ramerr_set", 32'(ramerr), 32'h1);
    chk("err_after_dload0", dload[0], 32'h0);
    nxt; #1;
    chk("err_ramerr_sticky", 32'(ramerr), 32'h1);

    // abort while BUSY; pointer (CPU0) must survive the abort
    nxt; dREN = 2'b01; daddr[0] = 32'h700; daddr[1] = 32'h710; #1;
    chk("ab_idle_state", 32'(dbg_state), 32'h0);
    nxt; ramstate = BUSY; #1;
    chk("ab_busy_ramREN", 32'(ramREN), 32'h1);
    chk("ab_busy_dwait", 32'(dwait), 32'h3);
    nxt; dREN = 2'b00; #1;
    chk("ab_drop_state", 32'(dbg_state), 32'h1);
    chk("ab_drop_ramREN", 32'(ramREN), 32'h0);
    chk("ab_drop_ramaddr", ramaddr, 32'h0);
    chk("ab_drop_dwait", 32'(dwait), 32'h3);
    nxt; dREN = 2'b11; #1;
    chk("ab_back_state", 32'(dbg_state), 32'h0);
    chk("ab_back_dwait", 32'(dwait), 32'h3);
    nxt; ramstate = ACCESS; #1;
    chk("ab_rr_dwait", 32'(dwait), 32'h2);
    chk("ab_rr_ramaddr", ramaddr, 32'h700);

    // reset in the middle of SERVE
    nxt; dREN = 2'b10; daddr[1] = 32'h800; ramstate = FREE; #1;
    chk("mr_idle_state", 32'(dbg_state), 32'h0);
    nxt; ramstate = BUSY; #1;
    chk("mr_busy_ramREN", 32'(ramREN), 32'h1);
    chk("mr_busy_ramaddr", ramaddr, 32'h800);
    chk("mr_busy_state", 32'(dbg_state), 32'h1);
    #1; nRST = 1'b0; ramstate = ACCESS; #1;
    chk("mr_dwait", 32'(dwait), 32'h3);
    chk("mr_ramREN", 32'(ramREN), 32'h0);
    chk("mr_ramWEN", 32'(ramWEN), 32'h0);
    chk("mr_ramerr", 32'(ramerr), 32'h0);
    chk("mr_state", 32'(dbg_state), 32'h0);
    chk("mr_dload1", dload[1], 32'h0);
    #2; nRST = 1'b1; dREN = 2'b00; ramstate = FREE;
    nxt; #1;
    chk("end_state", 32'(dbg_state), 32'h0);
    chk("end_dwait", 32'(dwait), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
